display_arbiter: RTL



---
 rtl/display_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// Fixed-priority owner of the 4-digit display: minimum dwell per message, blank gap between messages.
// Optional macro DISP_PREEMPT_EN: a lower-index request replaces the current message at once, with no done and no gap.
module display_arbiter #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int GAP_CYCLES   = 5_000_000,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  hold,
  input  logic [63:0] msg_flat,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy,
  output logic [15:0] graphics
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0]      BLANK      = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hold_l;
  logic [1:0]       cur;
  logic             take;
  logic [1:0]       take_sel;
  logic             show_exit;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd3;
    for (int k = 3; k >= 0; k--) begin
      if (v[k]) lowest = 2'(k);
    end
  endfunction

  // take: load a new message snapshot this edge (from IDLE, or a preempting request)
  always_comb begin
    take     = 1'b0;
    take_sel = lowest(req);
    if (state == IDLE) take = |req;
`ifdef DISP_PREEMPT_EN
    if (state == SHOW) begin
      take     = |(req & (grant - 4'd1));
      take_sel = lowest(req & (grant - 4'd1));
    end
`endif
  end

  assign show_exit = (cnt == DWELL_LAST) && (!hold_l || !req[cur]);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      graphics <= BLANK;
      cnt      <= '0;
      hold_l   <= 1'b0;
      cur      <= '0;
    end else begin
      done <= '0;
      if (take) begin
        state    <= SHOW;
        grant    <= 4'b0001 << take_sel;
        graphics <= msg_flat[{take_sel, 4'b0000} +: 16];
        hold_l   <= hold[take_sel];
        cur      <= take_sel;
        cnt      <= '0;
      end else begin
        case (state)
          SHOW: begin
            if (show_exit) begin
              done     <= grant;
              grant    <= '0;
              graphics <= BLANK;
              cnt      <= '0;
              state    <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end else if (cnt != DWELL_LAST) begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
